iteration_uart_tx: RTL
======================

ITERATION_UART_TX -- requirements
Module: iteration_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 625, meaning clk_72MHz cycles per UART bit (115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk_72MHz  input  1  the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port data_avl  input  1  frame-available flag from the octo manager; held high until the frame is released.
REQ-005 The block SHALL have port sensor_iterations  input  272  frame payload from the octo manager; valid while data_avl=1.
REQ-006 The block SHALL have port reset_parser  output  1  one-cycle release pulse to the octo manager parser.
REQ-007 The block SHALL have port tx  output  1  UART 8N1 serial line to host, idle high.
REQ-008 The block SHALL have port busy  output  1  high while a frame is being transmitted.
REQ-009 The block SHALL have port frame_dropped  output  1  one-cycle pulse when a frame arrives while busy.
REQ-010 The block SHALL have port drop_count  output  8  saturating count of dropped frames.

Function
REQ-011 The block SHALL register data_avl and define a frame event as data_avl=1 with its registered value=0 (rising edge); a level held high SHALL produce exactly one event.
REQ-012 On an event with state IDLE, the block SHALL latch sensor_iterations into a 272-bit frame register on that edge and enter START for byte 0.
REQ-013 On every event, captured or dropped, the block SHALL drive reset_parser=1 for exactly one cycle, in the cycle after the event.
REQ-014 On an event with state not IDLE (including the final stop-bit cycle), the block SHALL NOT alter the frame register or tx sequence, SHALL pulse frame_dropped for one cycle with reset_parser, and SHALL increment drop_count, saturating at 255.
REQ-015 The transmitted frame SHALL be 36 bytes: byte 0 = 0xA5; bytes 1..34 = sensor_iterations[271:264] down to [7:0], MSB byte first; byte 35 = XOR of bytes 1..34.
REQ-016 The checksum SHALL be accumulated during transmission from the latched register, not from the live input.
REQ-017 Each byte SHALL be sent as start bit 0, eight data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles via a 16-bit counter.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP: IDLE->START on capture; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->START (next byte) if byte index<35, else STOP->IDLE.
REQ-019 Bytes SHALL be back-to-back with no idle gap; a full frame SHALL last exactly 360*CLKS_PER_BIT cycles from first start-bit cycle to the last stop-bit cycle inclusive.
REQ-020 tx SHALL go low in the first cycle after the capture edge; tx SHALL be 1 in IDLE.
REQ-021 busy SHALL be 1 exactly when state is not IDLE.
REQ-022 sensor_iterations SHALL be ignored while data_avl=0.

Reset
REQ-023 While reset_n=0, the block SHALL immediately force tx=1, busy=0, reset_parser=0, frame_dropped=0, drop_count=0, state IDLE, byte index 0, bit counters 0, registered data_avl=0.
REQ-024 A reset asserted mid-frame SHALL abandon the partial frame; no byte is resumed after release.
REQ-025 After reset_n release, a data_avl already high SHALL count as an event in the first clocked cycle.

Verification
REQ-026 The bench SHALL apply reset_n=0 with tx toggling mid-frame -> tx=1, busy=0, reset_parser=0, drop_count=0 in the same cycle.
REQ-027 The bench SHALL run CLKS_PER_BIT=4 with payload bytes 0x01..0x22 -> serial bytes A5,01..22,23; frame lasts 1440 cycles; busy falls afterward.
REQ-028 The bench SHALL hold data_avl high 20 cycles -> one capture, reset_parser high exactly one cycle, one cycle after the rise.
REQ-029 The bench SHALL raise a second data_avl edge during byte 5 with a different payload -> frame_dropped pulse, drop_count=1, reset_parser pulse, transmitted bytes unchanged.
REQ-030 The bench SHALL assert reset_n during byte 10, then release and raise data_avl -> a new frame beginning 0xA5 with correct checksum.
REQ-031 The bench SHALL generate 300 edges during one long frame (CLKS_PER_BIT=65535) -> drop_count=255, with one frame_dropped pulse per edge.

Source files
------------

// File: rtl/iteration_uart_tx.sv
// iteration_uart_tx
//   Serialises one 272-bit sensor frame from the octo manager as a 36-byte
//   UART 8N1 packet: sync byte 0xA5, 34 payload bytes (MSB byte first) and
//   an XOR checksum over the payload bytes.
//
// Ports
//   clk_72MHz          in   system clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   data_avl           in   frame-available level from the octo manager
//   sensor_iterations  in   272-bit frame payload, valid while data_avl=1
//   reset_parser       out  one-cycle release pulse, cycle after each frame event
//   tx                 out  serial line, idle high
//   busy               out  high while a frame is on the line
//   frame_dropped      out  one-cycle pulse when a frame arrives while busy
//   drop_count         out  saturating count of dropped frames
//
// state | meaning
// IDLE  | line idle (tx=1), waiting for a data_avl rising edge
// START | start bit (tx=0) of the current byte
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1); next byte follows immediately or frame ends
module iteration_uart_tx #(
  parameter int CLKS_PER_BIT = 625
) (
  input  logic         clk_72MHz,
  input  logic         reset_n,
  input  logic         data_avl,
  input  logic [271:0] sensor_iterations,
  output logic         reset_parser,
  output logic         tx,
  output logic         busy,
  output logic         frame_dropped,
  output logic [7:0]   drop_count
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [5:0]  LAST_BYTE = 6'd35;

  state_t       state;
  logic         data_avl_q;
  logic [271:0] frame_q;
  logic [5:0]   byte_idx;
  logic [2:0]   bit_idx;
  logic [15:0]  clk_cnt;
  logic [7:0]   shift_q;
  logic [7:0]   chk_q;

  logic         frame_event;
  logic [5:0]   next_idx;
  logic [8:0]   next_shift;
  logic [7:0]   next_payload;
  logic [7:0]   next_byte;

  assign busy = (state != IDLE);

  // Payload byte k (1..34) sits at frame_q[279-8k -: 8]; the checksum byte
  // reuses next_byte so the STOP->START hand-off loads either one.
  always_comb begin
    frame_event  = data_avl & ~data_avl_q;
    next_idx     = byte_idx + 6'd1;
    next_shift   = 9'd272 - {next_idx, 3'b000};
    next_payload = 8'(frame_q >> next_shift);
    next_byte    = (next_idx == LAST_BYTE) ? chk_q : next_payload;
  end

  always_ff @(posedge clk_72MHz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      data_avl_q    <= 1'b0;
      frame_q       <= '0;
      byte_idx      <= '0;
      bit_idx       <= '0;
      clk_cnt       <= '0;
      shift_q       <= '0;
      chk_q         <= '0;
      tx            <= 1'b1;
      reset_parser  <= 1'b0;
      frame_dropped <= 1'b0;
      drop_count    <= '0;
    end else begin
      data_avl_q    <= data_avl;
      reset_parser  <= frame_event;
      frame_dropped <= frame_event && (state != IDLE);
      if (frame_event && (state != IDLE) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (frame_event) begin
            frame_q  <= sensor_iterations;
            state    <= START;
            tx       <= 1'b0;
            byte_idx <= '0;
            bit_idx  <= '0;
            clk_cnt  <= BIT_LAST;
            shift_q  <= SYNC_BYTE;
            chk_q    <= '0;
          end
        end

        START: begin
          if (clk_cnt == 16'd0) begin
            state   <= DATA;
            tx      <= shift_q[0];
            bit_idx <= '0;
            clk_cnt <= BIT_LAST;
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end

        DATA: begin
          if (clk_cnt == 16'd0) begin
            clk_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end

        STOP: begin
          if (clk_cnt == 16'd0) begin
            if (byte_idx == LAST_BYTE) begin
              state    <= IDLE;
              tx       <= 1'b1;
              byte_idx <= '0;
            end else begin
              state    <= START;
              tx       <= 1'b0;
              byte_idx <= next_idx;
              shift_q  <= next_byte;
              clk_cnt  <= BIT_LAST;
              if (next_idx != LAST_BYTE)
                chk_q <= chk_q ^ next_payload;
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
